// File: rtl/stdcore_pack_pkg.sv
// Shared stdcore definitions: width helper and default sizing for the narrow-to-wide packer.
// Imported by the packer and its interface so CW is derived identically everywhere.
package stdcore_pack_pkg;

  localparam int unsigned DefaultDw    = 8;
  localparam int unsigned DefaultRatio = 4;

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stdcore_pack_if.sv
// Producer (p side) and consumer (c side) handshake bundle of the packer.
// The packer sits on the slave modport; the surrounding producer/consumer on master.
interface stdcore_pack_if
  import stdcore_pack_pkg::*;
#(
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned RATIO = DefaultRatio
);

  localparam int unsigned CW = clog2(RATIO + 1);

  logic [DW-1:0]       p;
  logic                p_last;
  logic                p_val;
  logic                p_rdy;
  logic [DW*RATIO-1:0] c;
  logic [CW-1:0]       c_cnt;
  logic                c_last;
  logic                c_val;
  logic                c_rdy;

  modport master (
    output p, p_last, p_val, c_rdy,
    input  p_rdy, c, c_cnt, c_last, c_val
  );

  modport slave (
    input  p, p_last, p_val, c_rdy,
    output p_rdy, c, c_cnt, c_last, c_val
  );

endinterface

// File: rtl/stdcore_pack.sv
// Narrow-to-wide packer: gathers RATIO DW-bit words into one wide word behind a single
// output register; p_last closes a packet early with a lane count in c_cnt.
module stdcore_pack
  import stdcore_pack_pkg::*;
#(
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned RATIO = DefaultRatio
) (
  input logic           clk,
  input logic           rst_n,
  stdcore_pack_if.slave bus
);

  localparam int unsigned CW = clog2(RATIO + 1);
  localparam int unsigned NW = clog2(RATIO);
  localparam int unsigned OW = DW * RATIO;

  logic [NW-1:0]             cnt_q, cnt_d;
  logic [RATIO-2:0][DW-1:0]  acc_q, acc_d;
  logic [OW-1:0]             c_q, c_d;
  logic [CW-1:0]             c_cnt_q, c_cnt_d;
  logic                      c_last_q, c_last_d;
  logic                      c_val_q, c_val_d;
  logic                      p_rdy;
  logic                      accept;
  logic                      at_top;
  logic                      close;

  // Any held output word stalls the input entirely, including accumulation.
  assign p_rdy  = !c_val_q || bus.c_rdy;
  assign accept = bus.p_val && p_rdy;
  assign at_top = (cnt_q == NW'(RATIO - 1));
  assign close  = accept && (bus.p_last || at_top);

  always_comb begin : acc_next
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (close) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      for (int unsigned l = 0; l < RATIO - 1; l++) begin
        if (cnt_q == NW'(l)) begin
          acc_d[l] = bus.p;
        end
      end
      cnt_d = cnt_q + NW'(1);
    end
  end

  always_comb begin : out_next
    c_d      = c_q;
    c_cnt_d  = c_cnt_q;
    c_last_d = c_last_q;
    c_val_d  = c_val_q;
    if (c_val_q && bus.c_rdy) begin
      c_val_d = 1'b0;
    end
    if (close) begin
      // Lanes below cnt come from acc, lane cnt is the closing word, lanes above stay 0.
      c_d = '0;
      for (int unsigned l = 0; l < RATIO - 1; l++) begin
        if (NW'(l) < cnt_q) begin
          c_d[l*DW +: DW] = acc_q[l];
        end
      end
      for (int unsigned l = 0; l < RATIO; l++) begin
        if (cnt_q == NW'(l)) begin
          c_d[l*DW +: DW] = bus.p;
        end
      end
      c_cnt_d  = CW'(cnt_q) + CW'(1);
      c_last_d = bus.p_last;
      c_val_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      c_q      <= '0;
      c_cnt_q  <= '0;
      c_last_q <= 1'b0;
      c_val_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      c_cnt_q  <= c_cnt_d;
      c_last_q <= c_last_d;
      c_val_q  <= c_val_d;
    end
  end

  assign bus.p_rdy  = p_rdy;
  assign bus.c      = c_q;
  assign bus.c_cnt  = c_cnt_q;
  assign bus.c_last = c_last_q;
  assign bus.c_val  = c_val_q;

endmodule

// File: tb/tb_stdcore_pack.sv
// Bench for stdcore_pack (DW=8, RATIO=4): directed scenarios plus a randomized run
// scored against a lane-queue reference model of the packing rules.
module tb_stdcore_pack;

  localparam int unsigned DW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OW    = DW * RATIO;
  localparam int unsigned CW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stdcore_pack_if #(.DW(DW), .RATIO(RATIO)) bus ();

  stdcore_pack #(.DW(DW), .RATIO(RATIO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bytes gathered so far, plus the word currently presented.
  logic [DW-1:0] lanes_m[$];
  bit            pend_m   = 1'b0;
  logic [OW-1:0] word_m   = '0;
  int            cnt_m    = 0;
  bit            last_m   = 1'b0;
  int            closed_m = 0;
  int            out_dut  = 0;

  task automatic model_update();
    bit rdy;
    bit acc;
    rdy = !pend_m || bus.c_rdy;
    acc = bus.p_val && rdy;
    if (!rst_n) begin
      lanes_m.delete();
      pend_m = 1'b0;
      word_m = '0;
      cnt_m  = 0;
      last_m = 1'b0;
    end else begin
      if (pend_m && bus.c_rdy) pend_m = 1'b0;
      if (acc) begin
        lanes_m.push_back(bus.p);
        if (bus.p_last || lanes_m.size() == RATIO) begin
          word_m = '0;
          foreach (lanes_m[i]) word_m[i*DW +: DW] = lanes_m[i];
          cnt_m    = lanes_m.size();
          last_m   = bus.p_last;
          pend_m   = 1'b1;
          closed_m = closed_m + 1;
          lanes_m.delete();
        end
      end
    end
  endtask

  task automatic drive(input logic pv, input logic [DW-1:0] d, input logic pl, input logic cr);
    bus.p_val  = pv;
    bus.p      = d;
    bus.p_last = pl;
    bus.c_rdy  = cr;
    #2;
  endtask

  task automatic tick();
    if (rst_n && bus.c_val && bus.c_rdy) out_dut = out_dut + 1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (bus.c_val !== 1'b0) $display("FAIL reset c_val: got %b want 0", bus.c_val);
    else n_pass++;
    n_checks++;
    if (bus.c !== 32'h0) $display("FAIL reset c: got %h want 00000000", bus.c);
    else n_pass++;
    n_checks++;
    if (bus.c_cnt !== 3'd0 || bus.c_last !== 1'b0)
      $display("FAIL reset cnt/last: got %0d/%b want 0/0", bus.c_cnt, bus.c_last);
    else n_pass++;
    n_checks++;
    if (bus.p_rdy !== 1'b1) $display("FAIL reset p_rdy: got %b want 1", bus.p_rdy);
    else n_pass++;
  endtask

  task automatic test_full_word();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1);
      tick();
      if (i == 3) begin
        n_checks++;
        if (bus.c_val !== 1'b0) $display("FAIL full_early c_val: got %b want 0", bus.c_val);
        else n_pass++;
      end
    end
    n_checks++;
    if (bus.c_val !== 1'b1 || bus.c !== 32'h04030201)
      $display("FAIL full_word c: got %b/%h want 1/04030201", bus.c_val, bus.c);
    else n_pass++;
    n_checks++;
    if (bus.c_cnt !== 3'd4 || bus.c_last !== 1'b0)
      $display("FAIL full_word cnt/last: got %0d/%b want 4/0", bus.c_cnt, bus.c_last);
    else n_pass++;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (bus.c_val !== 1'b0) $display("FAIL full_drain c_val: got %b want 0", bus.c_val);
    else n_pass++;
  endtask

  task automatic test_partial();
    drive(1'b1, 8'hAA, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'hBB, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (bus.c_val !== 1'b1 || bus.c !== 32'h0000BBAA)
      $display("FAIL partial c: got %b/%h want 1/0000bbaa", bus.c_val, bus.c);
    else n_pass++;
    n_checks++;
    if (bus.c_cnt !== 3'd2 || bus.c_last !== 1'b1)
      $display("FAIL partial cnt/last: got %0d/%b want 2/1", bus.c_cnt, bus.c_last);
    else n_pass++;
    // Next packet must restart at lane 0; closing on lane 3 gives a full last word.
    drive(1'b1, 8'hCC, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'hDD, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'hFF, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (bus.c !== 32'hFFEEDDCC || bus.c_cnt !== 3'd4 || bus.c_last !== 1'b1)
      $display("FAIL lane0_restart: got %h/%0d/%b want ffeeddcc/4/1",
               bus.c, bus.c_cnt, bus.c_last);
    else n_pass++;
  endtask

  task automatic test_single();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (bus.c_val !== 1'b1 || bus.c !== 32'h0000005A || bus.c_cnt !== 3'd1 || bus.c_last !== 1'b1)
      $display("FAIL single: got %b/%h/%0d/%b want 1/0000005a/1/1",
               bus.c_val, bus.c, bus.c_cnt, bus.c_last);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h61 + i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 8'h71, 1'b0, 1'b0);
    n_checks++;
    if (bus.p_rdy !== 1'b0) $display("FAIL stall p_rdy: got %b want 0", bus.p_rdy);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.c_val !== 1'b1 || bus.c !== 32'h64636261)
        $display("FAIL stall hold: got %b/%h want 1/64636261", bus.c_val, bus.c);
      else n_pass++;
    end
    // Raise c_rdy in the same cycle a close arrives: old word leaves, new one loads.
    drive(1'b1, 8'h81, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (bus.c_val !== 1'b1 || bus.c !== 32'h00000081)
      $display("FAIL b2b first: got %b/%h want 1/00000081", bus.c_val, bus.c);
    else n_pass++;
    drive(1'b1, 8'h82, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (bus.c_val !== 1'b1 || bus.c !== 32'h00000082)
      $display("FAIL b2b second: got %b/%h want 1/00000082", bus.c_val, bus.c);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h91 + i), 1'b0, 1'b1);
      tick();
    end
    n_checks++;
    if (bus.c_val !== 1'b1 || bus.c !== 32'h94939291)
      $display("FAIL b2b full: got %b/%h want 1/94939291", bus.c_val, bus.c);
    else n_pass++;
  endtask

  task automatic test_reset_midpacket();
    drive(1'b1, 8'hA1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'hA2, 1'b0, 1'b1);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 8'hA3, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.c_val !== 1'b0 || bus.c !== 32'h0)
      $display("FAIL midreset c: got %b/%h want 0/00000000", bus.c_val, bus.c);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(8'h11 * i), 1'b0, 1'b1);
      tick();
    end
    n_checks++;
    if (bus.c_val !== 1'b1 || bus.c !== 32'h44332211 || bus.c_cnt !== 3'd4)
      $display("FAIL midreset refill: got %b/%h/%0d want 1/44332211/4",
               bus.c_val, bus.c, bus.c_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int   words;
    int   cyc;
    logic pv, pl, cr;
    bit   done;
    words = 0;
    cyc   = 0;
    while (words < 10000 && cyc < 40000) begin
      pv = ($urandom_range(0, 9) >= 3);
      pl = ($urandom_range(0, 4) == 0);
      cr = ($urandom_range(0, 9) >= 3);
      drive(pv, 8'($urandom), pl, cr);
      n_checks++;
      if (bus.p_rdy !== (!pend_m || cr))
        $display("FAIL rand p_rdy cyc %0d: got %b want %b", cyc, bus.p_rdy, !pend_m || cr);
      else n_pass++;
      if (pv && (!pend_m || cr)) words++;
      tick();
      cyc++;
      n_checks++;
      if (bus.c_val !== pend_m || bus.c !== word_m || bus.c_cnt !== CW'(cnt_m)
          || bus.c_last !== last_m)
        $display("FAIL rand out cyc %0d: got %b/%h/%0d/%b want %b/%h/%0d/%b", cyc,
                 bus.c_val, bus.c, bus.c_cnt, bus.c_last, pend_m, word_m, cnt_m, last_m);
      else n_pass++;
    end
    n_checks++;
    if (words < 10000) $display("FAIL rand budget: got %0d words want 10000", words);
    else n_pass++;
    // Close any open packet and drain, then every closed word must have left exactly once.
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      drive(1'b1, 8'hE7, 1'b1, 1'b1);
      done = 1'b1;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
    end
    n_checks++;
    if (out_dut !== closed_m || bus.c_val !== 1'b0)
      $display("FAIL rand count: got %0d words out (c_val %b) want %0d", out_dut, bus.c_val,
               closed_m);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.p      = '0;
    bus.p_last = 1'b0;
    bus.p_val  = 1'b0;
    bus.c_rdy  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_full_word();
    test_partial();
    test_single();
    test_back_to_back();
    test_reset_midpacket();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
